dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's MEM-stage data accesses. It replaces the single-cycle data memory with a multi-cycle word store.
//  Accepts one load or store per valid/ready handshake and returns a one-cycle response after LATENCY cycles.
//  Drives stall so the pipeline holds its EX/MEM contents until the response arrives.
// PARAMETERS
//  ADDR_WIDTH   32   byte-address width of req_addr
//  DATA_WIDTH   32   word width; fixed at 32 for this design
//  DEPTH_WORDS  256  words of storage (power of 2); index = req_addr[log2(DEPTH_WORDS)+1:2]
//  LATENCY      2    cycles from accept to resp_valid; legal range 1..15
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  req_valid   in   1           pipeline presents an access (mem_read | mem_write)
//  req_write   in   1           1 = store, 0 = load
//  req_addr    in   ADDR_WIDTH  byte address (ALU result)
//  req_wdata   in   DATA_WIDTH  store data (rt value)
//  req_ready   out  1           responder can accept this cycle
//  resp_valid  out  1           one-cycle pulse: access complete
//  resp_rdata  out  DATA_WIDTH  load data; valid only with resp_valid
//  resp_err    out  1           misaligned access; valid only with resp_valid
//  stall       out  1           hold pipeline: req_valid & ~resp_valid
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP. Reset -> IDLE. Outputs at reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
//  - IDLE: req_ready=1. On req_valid, latch write, addr, wdata and err=(addr[1:0]!=0). Load cnt=LATENCY-1.
//    If LATENCY==1, go to RESP; otherwise go to WAIT.
//  - WAIT: req_ready=0. Decrement cnt each cycle. When cnt==1, go to RESP. Inputs are ignored; the latched copy is used.
//  - RESP: resp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE. resp_valid rises exactly LATENCY cycles after the accept edge.
//  - A store commits to the array on the clock edge that ends RESP. A store with err=1 never commits.
//  - Loads: resp_rdata = mem[index] as of RESP entry, or 0 if err. Stores: resp_rdata=0.
//  - Read-after-write: a load accepted after a store's RESP returns the new data.
//  - Address wrap: upper address bits above the index are ignored; the index wraps modulo DEPTH_WORDS.
//  - stall is combinational. The pipeline holds req_* stable while stall=1. It advances on the RESP edge and may present the next request in the following IDLE cycle.
//    Minimum spacing is LATENCY+1 cycles per access.
//  - Reset mid-operation (WAIT or RESP): return to IDLE; the pending store is dropped (not committed); resp_valid=0 next cycle.
//    Array contents survive reset.
//  - The array is not reset. Reading an unwritten word returns X in simulation.
// CONFIGURATION
//  DMEM_BYTE_STROBE_EN defined:
//    - Adds port req_be (in, 4): per-byte write strobe, latched at accept.
//    - Stores write only bytes whose req_be bit is 1; req_be==0 acts as a no-op store that still responds.
//    - Misalignment is checked only when req_be==4'hF.
//  DMEM_BYTE_STROBE_EN undefined:
//    - No req_be port; every store writes the full word.
// TESTING
//  1 reset=1 for 2 cycles -> req_ready=1, resp_valid=0, stall=0.
//  2 Store 0xDEADBEEF @0x10 (LATENCY=2), then load @0x10 -> store resp at +2 cycles; load resp_rdata=0xDEADBEEF at +2; stall high for 2 cycles each.
//  3 Load @0x13 -> resp_err=1 and resp_rdata=0; store 0x1 @0x12 -> err=1 and word @0x10 unchanged.
//  4 Store 0x55 @0x404 (DEPTH_WORDS=256), then load @0x004 -> 0x55 (index wrap).
//  5 Store 0xAAAA0000 @0x20; assert reset in the WAIT cycle; then load @0x20 -> old value, not 0xAAAA0000; FSM in IDLE after reset.
//  6 LATENCY=1: four back-to-back loads -> resp_valid every 2nd cycle, no dropped or duplicated responses.
//    With DMEM_BYTE_STROBE_EN: store 0x11223344 with be=4'b0011 over 0xFFFFFFFF -> 0xFFFF3344.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and its data-memory responder.
// req_be exists only when DMEM_BYTE_STROBE_EN is defined.
interface dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]            req_be;
`endif
  logic                  req_ready;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  stall;

  modport master (
`ifdef DMEM_BYTE_STROBE_EN
    output req_be,
`endif
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
`ifdef DMEM_BYTE_STROBE_EN
    input  req_be,
`endif
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word store answering MEM-stage loads/stores; DMEM_BYTE_STROBE_EN adds per-byte store strobes.
// Latency: resp_valid is asserted LATENCY cycles after the accept cycle, for exactly one cycle.
// Backpressure: one access in flight; req_ready only in IDLE, stall holds the pipeline until the response.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dmem_responder: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req_ready_c;

  logic                  lat_write_q;
  logic                  lat_err_q;
  logic [IDX_W-1:0]      lat_idx_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [3:0]            lat_be_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [IDX_W-1:0]      in_idx;
  logic                  in_err;
  logic [3:0]            in_be;
  logic                  accept;
  logic                  enter_resp;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_write;
  logic                  rd_err;
  logic                  commit;
  logic                  unused_addr;

  assign in_idx      = bus.req_addr[IDX_W+1:2];
  assign unused_addr = ^bus.req_addr[ADDR_WIDTH-1:IDX_W+2];

`ifdef DMEM_BYTE_STROBE_EN
  assign in_be  = bus.req_be;
  // Partial-word stores are allowed at any alignment; only full-word accesses are checked.
  assign in_err = (bus.req_addr[1:0] != 2'b00) && (bus.req_be == 4'hF);
`else
  assign in_be  = 4'hF;
  assign in_err = (bus.req_addr[1:0] != 2'b00);
`endif

  assign accept = (state_q == IDLE) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.stall      = bus.req_valid & ~bus.resp_valid;

  // With LATENCY==1 RESP is entered straight from IDLE, before the latched copy exists.
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign rd_idx     = (state_q == IDLE) ? in_idx         : lat_idx_q;
  assign rd_write   = (state_q == IDLE) ? bus.req_write  : lat_write_q;
  assign rd_err     = (state_q == IDLE) ? in_err         : lat_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write_q <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= 4'h0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        lat_write_q <= bus.req_write;
        lat_err_q   <= in_err;
        lat_idx_q   <= in_idx;
        lat_wdata_q <= bus.req_wdata;
        lat_be_q    <= in_be;
      end
      if (enter_resp) begin
        err_q   <= rd_err;
        rdata_q <= (rd_write || rd_err) ? '0 : mem[rd_idx];
      end else begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Stores land on the edge that closes RESP; a reset on that edge drops them.
  assign commit = (state_q == RESP) && lat_write_q && !lat_err_q && !reset;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be_q[b]) begin
          mem[lat_idx_q][8*b +: 8] <= lat_wdata_q[8*b +: 8];
        end
      end
    end
  end
endmodule
